// File: rtl/apb_conv_pkg.sv
// Shared constants, types and address decode for the APB convolution register block.
package apb_conv_pkg;

   localparam int PIX_W         = 3;
   localparam int FILT_SIZE     = 5;
   localparam int ROW_LEN       = 28;
   localparam int WORDS_PER_ROW = 3;
   localparam int WORD_PIX      = 10;
   localparam int WORD_W        = WORD_PIX * PIX_W;
   localparam int TAPS          = FILT_SIZE * FILT_SIZE;
   localparam int FILT_W        = TAPS * PIX_W;
   localparam int FILT01_TAPS   = 2 * FILT_SIZE;
   localparam int FILT2_W       = FILT_SIZE * PIX_W;

   localparam logic [11:0] OFF_CTRL     = 12'h500;
   localparam logic [11:0] OFF_STATUS   = 12'h504;
   localparam logic [11:0] OFF_ROW_DATA = 12'h508;
   localparam logic [11:0] OFF_FILT0    = 12'h900;
   localparam logic [11:0] OFF_FILT1    = 12'h904;
   localparam logic [11:0] OFF_FILT2    = 12'h908;

   localparam int ST_BUSY      = 0;
   localparam int ST_ROW_DONE  = 1;
   localparam int ST_CHAN_DONE = 2;
   localparam int ST_FULL      = 3;
   localparam int ST_CNT_LSB   = 4;
   localparam int ST_CNT_MSB   = 6;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_CTRL,
      REG_STATUS,
      REG_ROW_DATA,
      REG_FILT0,
      REG_FILT1,
      REG_FILT2
   } reg_sel_e;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [1:0]        idx;
   } row_word_t;

   // Byte-lane bits are dropped by the caller; only the word address is decoded.
   function automatic reg_sel_e decode_reg(input logic [9:0] word_addr);
      reg_sel_e sel;
      sel = REG_NONE;
      if (word_addr == OFF_CTRL[11:2])          sel = REG_CTRL;
      else if (word_addr == OFF_STATUS[11:2])   sel = REG_STATUS;
      else if (word_addr == OFF_ROW_DATA[11:2]) sel = REG_ROW_DATA;
      else if (word_addr == OFF_FILT0[11:2])    sel = REG_FILT0;
      else if (word_addr == OFF_FILT1[11:2])    sel = REG_FILT1;
      else if (word_addr == OFF_FILT2[11:2])    sel = REG_FILT2;
      return sel;
   endfunction

endpackage

// File: rtl/conv_word_fifo.sv
// Synchronous row-word FIFO with occupancy count; depth need not be a power of two.
module conv_word_fifo
   import apb_conv_pkg::*;
#(
   parameter int DEPTH = 6,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             push,
   input  row_word_t        push_word,
   input  logic             pop,
   output row_word_t        head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   row_word_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; pointers and count define validity, so flushing them empties the FIFO.
   always_ff @(posedge HCLK) begin
      if (do_push) mem[wr_ptr] <= push_word;
   end

endmodule

// File: rtl/apb_conv_regs.sv
// APB register front-end for the convolution core: filters, row-word FIFO, start/status.
// Optional build macro APB_CONV_REGS_SLVERR_EN enables PSLVERR on illegal accesses.
module apb_conv_regs
   import apb_conv_pkg::*;
#(
   parameter int FIFO_DEPTH = 6
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic [11:0]         PADDR,
   input  logic [31:0]         PWDATA,
   input  logic                PWRITE,
   input  logic                PSEL,
   input  logic                PENABLE,
   output logic [31:0]         PRDATA,
   output logic                PREADY,
   output logic                PSLVERR,
   output logic [FILT_W-1:0]   filt_o,
   output logic [WORD_W-1:0]   pix_data_o,
   output logic [1:0]          pix_idx_o,
   output logic                pix_valid_o,
   input  logic                pix_ready_i,
   output logic                start_o,
   input  logic                row_done_i,
   input  logic                chan_done_i
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   reg_sel_e              sel;
   logic                  access;
   logic                  stall;
   logic                  xfer;
   logic                  wr_xfer;
   logic                  rd_xfer;
   logic                  wr_ok;
   logic                  status_rd;

   logic [WORD_W-1:0]     filt0;
   logic [WORD_W-1:0]     filt1;
   logic [FILT2_W-1:0]    filt2;
   logic [1:0]            word_idx;
   logic                  busy;
   logic                  row_done_st;
   logic                  chan_done_st;

   row_word_t             push_word;
   row_word_t             head;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [2:0]            cnt_disp;
   logic [31:0]           status;

   wire unused_bits = ^{PADDR[1:0], PWDATA[31:30]};

   assign sel     = decode_reg(PADDR[11:2]);
   assign access  = PSEL & PENABLE;
   // Only a ROW_DATA write into a full FIFO inserts wait states.
   assign stall   = access & PWRITE & (sel == REG_ROW_DATA) & fifo_full;
   assign PREADY  = ~stall;
   assign xfer    = access & PREADY;
   assign wr_xfer = xfer & PWRITE;
   assign rd_xfer = xfer & ~PWRITE;

`ifdef APB_CONV_REGS_SLVERR_EN
   logic slv_err;
   always_comb begin
      slv_err = 1'b0;
      case (sel)
         REG_NONE:               slv_err = 1'b1;
         REG_CTRL, REG_ROW_DATA: slv_err = ~PWRITE;
         REG_STATUS:             slv_err = PWRITE;
         default:                slv_err = 1'b0;
      endcase
   end
   assign PSLVERR = xfer & slv_err;
   assign wr_ok   = wr_xfer & ~slv_err;
`else
   assign PSLVERR = 1'b0;
   assign wr_ok   = wr_xfer;
`endif

   assign status_rd = rd_xfer & (sel == REG_STATUS);

   // Row-word FIFO feeding the core.
   assign push_word   = '{data: PWDATA[WORD_W-1:0], idx: word_idx};
   assign fifo_push   = wr_ok & (sel == REG_ROW_DATA);
   assign fifo_pop    = pix_valid_o & pix_ready_i;
   assign pix_valid_o = ~fifo_empty;
   assign pix_data_o  = head.data;
   assign pix_idx_o   = head.idx;

   conv_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .push      (fifo_push),
      .push_word (push_word),
      .pop       (fifo_pop),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         filt0    <= '0;
         filt1    <= '0;
         filt2    <= '0;
         word_idx <= '0;
      end else begin
         if (wr_ok && sel == REG_FILT0) filt0 <= PWDATA[WORD_W-1:0];
         if (wr_ok && sel == REG_FILT1) filt1 <= PWDATA[WORD_W-1:0];
         if (wr_ok && sel == REG_FILT2) filt2 <= PWDATA[FILT2_W-1:0];
         if (fifo_push) word_idx <= (word_idx == 2'(WORDS_PER_ROW - 1)) ? 2'd0 : word_idx + 2'd1;
      end
   end

   // Start is accepted only when idle; sticky events beat a clearing STATUS read.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         start_o      <= 1'b0;
         busy         <= 1'b0;
         row_done_st  <= 1'b0;
         chan_done_st <= 1'b0;
      end else begin
         start_o <= wr_ok & (sel == REG_CTRL) & PWDATA[0] & ~busy;
         if (wr_ok && sel == REG_CTRL && PWDATA[0] && !busy) busy <= 1'b1;
         else if (row_done_i)                                busy <= 1'b0;
         if (row_done_i)     row_done_st  <= 1'b1;
         else if (status_rd) row_done_st  <= 1'b0;
         if (chan_done_i)    chan_done_st <= 1'b1;
         else if (status_rd) chan_done_st <= 1'b0;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cnt_disp = (int'(fifo_count) > 7) ? 3'd7 : 3'(fifo_count);
      status = '0;
      status[ST_BUSY]                = busy;
      status[ST_ROW_DONE]            = row_done_st;
      status[ST_CHAN_DONE]           = chan_done_st;
      status[ST_FULL]                = fifo_full;
      status[ST_CNT_MSB:ST_CNT_LSB]  = cnt_disp;
   end

   always_comb begin
      PRDATA = '0;
      if (rd_xfer) begin
         case (sel)
            REG_STATUS: PRDATA = status;
            REG_FILT0:  PRDATA = {{(32-WORD_W){1'b0}}, filt0};
            REG_FILT1:  PRDATA = {{(32-WORD_W){1'b0}}, filt1};
            REG_FILT2:  PRDATA = {{(32-FILT2_W){1'b0}}, filt2};
            default:    PRDATA = '0;
         endcase
      end
   end

   // Registers hold the leftmost tap in the top field; filt_o is indexed by tap number.
   always_comb begin
      filt_o = '0;
      for (int k = 0; k < FILT01_TAPS; k++) begin
         filt_o[PIX_W*k+2 -: PIX_W] = filt0[PIX_W*(FILT01_TAPS-1-k)+2 -: PIX_W];
         filt_o[PIX_W*(FILT01_TAPS+k)+2 -: PIX_W] = filt1[PIX_W*(FILT01_TAPS-1-k)+2 -: PIX_W];
      end
      for (int k = 0; k < FILT_SIZE; k++) begin
         filt_o[PIX_W*(2*FILT01_TAPS+k)+2 -: PIX_W] = filt2[PIX_W*(FILT_SIZE-1-k)+2 -: PIX_W];
      end
   end

endmodule

// File: tb/tb_apb_conv_regs.sv
// Scoreboard bench for apb_conv_regs: directed APB/pixel vectors, queue-based monitors.
module tb_apb_conv_regs;

   logic        HCLK;
   logic        HRESETn;
   logic [11:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [74:0] filt_o;
   logic [29:0] pix_data_o;
   logic [1:0]  pix_idx_o;
   logic        pix_valid_o;
   logic        pix_ready_i;
   logic        start_o;
   logic        row_done_i;
   logic        chan_done_i;

`ifdef APB_CONV_REGS_SLVERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   typedef struct {
      logic        is_read;
      logic [31:0] data;
      logic        err;
   } apb_exp_t;

   apb_exp_t    apb_q[$];
   string       apb_name_q[$];
   logic [31:0] pix_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          start_seen = 0;

   apb_conv_regs dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PWRITE      (PWRITE),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR),
      .filt_o      (filt_o),
      .pix_data_o  (pix_data_o),
      .pix_idx_o   (pix_idx_o),
      .pix_valid_o (pix_valid_o),
      .pix_ready_i (pix_ready_i),
      .start_o     (start_o),
      .row_done_i  (row_done_i),
      .chan_done_i (chan_done_i)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // APB completion monitor.
   always @(negedge HCLK) begin
      if (HRESETn && PSEL && PENABLE && PREADY) begin
         if (apb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL apb_unexpected: completion at addr %0h with no expectation", PADDR);
         end else begin
            apb_exp_t e;
            string    nm;
            e  = apb_q.pop_front();
            nm = apb_name_q.pop_front();
            if (e.is_read) check({nm, "_prdata"}, 96'(PRDATA), 96'(e.data));
            check({nm, "_pslverr"}, 96'(PSLVERR), 96'(e.err));
         end
      end
   end

   // Pixel-word monitor.
   always @(negedge HCLK) begin
      if (HRESETn && pix_valid_o && pix_ready_i) begin
         if (pix_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pix_unexpected: got %0h with nothing expected", {pix_data_o, pix_idx_o});
         end else begin
            check("pix_word", 96'({pix_data_o, pix_idx_o}), 96'(pix_q.pop_front()));
         end
      end
   end

   always @(negedge HCLK) begin
      if (HRESETn && start_o) start_seen++;
   end

   task automatic apb_xfer(input string nm, input logic wr, input logic [11:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input logic pulse_chan);
      bit done;
      apb_q.push_back('{is_read: !wr, data: exp_rd, err: exp_err});
      apb_name_q.push_back(nm);
      @(posedge HCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      chan_done_i = pulse_chan;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge HCLK);
         if (PREADY) done = 1'b1;
      end
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; chan_done_i = 1'b0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: PREADY stayed 0, expected 1", nm);
         void'(apb_q.pop_back());
         void'(apb_name_q.pop_back());
      end
   endtask

   task automatic apb_write(input string nm, input logic [11:0] a, input logic [31:0] d,
                            input logic exp_err);
      apb_xfer(nm, 1'b1, a, d, 32'h0, exp_err, 1'b0);
   endtask

   task automatic apb_read(input string nm, input logic [11:0] a, input logic [31:0] exp,
                           input logic exp_err);
      apb_xfer(nm, 1'b0, a, 32'h0, exp, exp_err, 1'b0);
   endtask

   task automatic push_row(input string nm, input logic [31:0] d, input logic [29:0] exp_d,
                           input logic [1:0] exp_idx);
      pix_q.push_back({exp_d, exp_idx});
      apb_write(nm, 12'h508, d, 1'b0);
   endtask

   task automatic pop_n(input int n);
      @(posedge HCLK); #1;
      pix_ready_i = 1'b1;
      repeat (n) @(posedge HCLK);
      #1;
      pix_ready_i = 1'b0;
   endtask

   task automatic pulse_row_done();
      @(posedge HCLK); #1;
      row_done_i = 1'b1;
      @(posedge HCLK); #1;
      row_done_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_prdata"},  96'(PRDATA), 96'h0);
      check({tag, "_pready"},  96'(PREADY), 96'h1);
      check({tag, "_pslverr"}, 96'(PSLVERR), 96'h0);
      check({tag, "_start"},   96'(start_o), 96'h0);
      check({tag, "_pvalid"},  96'(pix_valid_o), 96'h0);
      check({tag, "_filt"},    96'(filt_o), 96'h0);
   endtask

   initial begin
      HRESETn = 1'b0;
      PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      pix_ready_i = 1'b0; row_done_i = 1'b0; chan_done_i = 1'b0;
      repeat (2) @(negedge HCLK);
      check_reset_outputs("reset");
      @(posedge HCLK); #1;
      HRESETn = 1'b1;

      // Filters: bulk pattern, then asymmetric taps to expose field ordering.
      apb_write("filt0_w", 12'h900, 32'h3FFF_FFFF, 1'b0);
      apb_write("filt1_w", 12'h904, 32'h0000_0000, 1'b0);
      apb_write("filt2_w", 12'h908, 32'h0000_7FFF, 1'b0);
      check("filt_taps0_9",   96'(filt_o[29:0]),  96'h3FFF_FFFF);
      check("filt_taps10_19", 96'(filt_o[59:30]), 96'h0);
      check("filt_taps20_24", 96'(filt_o[74:60]), 96'h7FFF);
      apb_read("filt0_r", 12'h900, 32'h3FFF_FFFF, 1'b0);
      apb_read("filt1_r", 12'h904, 32'h0, 1'b0);
      apb_read("filt2_r", 12'h908, 32'h0000_7FFF, 1'b0);
      apb_write("filt0_w2", 12'h900, 32'h0000_0007, 1'b0);
      apb_write("filt1_w2", 12'h904, 32'hFFFF_FFFF, 1'b0);
      apb_write("filt2_w2", 12'h908, 32'hFFFF_7000, 1'b0);
      check("filt_tap9_only",   96'(filt_o[29:0]),  96'h3800_0000);
      check("filt_row23_ones",  96'(filt_o[59:30]), 96'h3FFF_FFFF);
      check("filt_tap20_only",  96'(filt_o[74:60]), 96'h0007);
      apb_read("filt1_r2", 12'h904, 32'h3FFF_FFFF, 1'b0);
      apb_read("filt2_r2", 12'h908, 32'h0000_7000, 1'b0);
      apb_read("filt0_lane", 12'h903, 32'h0000_0007, 1'b0);
      apb_read("status_idle", 12'h504, 32'h0, 1'b0);

      // Three words of one row.
      push_row("row_w0", 32'h1234_5678, 30'h1234_5678, 2'd0);
      push_row("row_w1", 32'h0000_0000, 30'h0,         2'd1);
      push_row("row_w2", 32'h00AB_CDEF, 30'h00AB_CDEF, 2'd2);
      apb_read("status_cnt3", 12'h504, 32'h30, 1'b0);
      pop_n(3);
      apb_read("status_drained", 12'h504, 32'h0, 1'b0);

      // Fill to full, then a stalled seventh write released by one pop.
      push_row("fill0", 32'hC000_0111, 30'h0111, 2'd0);
      push_row("fill1", 32'hC000_0222, 30'h0222, 2'd1);
      push_row("fill2", 32'hC000_0333, 30'h0333, 2'd2);
      push_row("fill3", 32'hC000_0444, 30'h0444, 2'd0);
      push_row("fill4", 32'hC000_0555, 30'h0555, 2'd1);
      push_row("fill5", 32'hC000_0666, 30'h0666, 2'd2);
      apb_read("status_full", 12'h504, 32'h68, 1'b0);
      pix_q.push_back({30'h0BAD_CAFE, 2'd0});
      apb_q.push_back('{is_read: 1'b0, data: 32'h0, err: 1'b0});
      apb_name_q.push_back("stall_w");
      @(posedge HCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h508; PWDATA = 32'h0BAD_CAFE;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      @(negedge HCLK);
      check("stall_pready_c0", 96'(PREADY), 96'h0);
      @(posedge HCLK); #1;
      @(negedge HCLK);
      check("stall_pready_c1", 96'(PREADY), 96'h0);
      @(posedge HCLK); #1;
      pix_ready_i = 1'b1;
      @(negedge HCLK);
      check("stall_pready_popcyc", 96'(PREADY), 96'h0);
      @(posedge HCLK); #1;
      pix_ready_i = 1'b0;
      @(negedge HCLK);
      check("stall_released", 96'(PREADY), 96'h1);
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      apb_read("status_after_stall", 12'h504, 32'h68, 1'b0);
      pop_n(6);
      apb_read("status_empty", 12'h504, 32'h0, 1'b0);

      // Start handshake, busy lockout and sticky row_done.
      apb_write("ctrl_start", 12'h500, 32'h1, 1'b0);
      repeat (2) @(posedge HCLK);
      check("start_count_first", 96'(start_seen), 96'd1);
      apb_read("status_busy", 12'h504, 32'h1, 1'b0);
      apb_write("ctrl_busy", 12'h500, 32'h1, 1'b0);
      repeat (2) @(posedge HCLK);
      check("start_count_ignored", 96'(start_seen), 96'd1);
      pulse_row_done();
      apb_read("status_rowdone", 12'h504, 32'h2, 1'b0);
      apb_read("status_rowdone_clr", 12'h504, 32'h0, 1'b0);
      apb_write("ctrl_restart", 12'h500, 32'h1, 1'b0);
      repeat (2) @(posedge HCLK);
      check("start_count_restart", 96'(start_seen), 96'd2);

      // chan_done coincident with a clearing read survives.
      apb_xfer("status_chan_coinc", 1'b0, 12'h504, 32'h0, 32'h1, 1'b0, 1'b1);
      apb_read("status_chan_kept", 12'h504, 32'h5, 1'b0);
      apb_read("status_chan_clr", 12'h504, 32'h1, 1'b0);

      // Illegal accesses.
      apb_read("unmapped_r", 12'h600, 32'h0, ERR);
      apb_read("ctrl_r", 12'h500, 32'h0, ERR);
      apb_read("rowdata_r", 12'h508, 32'h0, ERR);
      apb_write("status_w", 12'h504, 32'hFFFF_FFFF, ERR);
      apb_write("unmapped_w", 12'h600, 32'hFFFF_FFFF, ERR);
      apb_read("status_unchanged", 12'h504, 32'h1, 1'b0);

      // Reset in the middle of a stalled write.
      push_row("rfill0", 32'h0000_0AAA, 30'h0AAA, 2'd1);
      push_row("rfill1", 32'h0000_0BBB, 30'h0BBB, 2'd2);
      push_row("rfill2", 32'h0000_0CCC, 30'h0CCC, 2'd0);
      push_row("rfill3", 32'h0000_0DDD, 30'h0DDD, 2'd1);
      push_row("rfill4", 32'h0000_0EEE, 30'h0EEE, 2'd2);
      push_row("rfill5", 32'h0000_0FFF, 30'h0FFF, 2'd0);
      @(posedge HCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h508; PWDATA = 32'h0000_0123;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      @(negedge HCLK);
      check("rst_stall_pready", 96'(PREADY), 96'h0);
      #2;
      HRESETn = 1'b0;
      PSEL = 1'b0; PENABLE = 1'b0;
      pix_q.delete();
      #1;
      check_reset_outputs("midstall_reset");
      @(posedge HCLK); #1;
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      apb_read("status_post_reset", 12'h504, 32'h0, 1'b0);
      apb_read("filt0_post_reset", 12'h900, 32'h0, 1'b0);
      push_row("post_reset_w", 32'h0000_0155, 30'h0155, 2'd0);
      apb_read("status_post_push", 12'h504, 32'h10, 1'b0);
      pop_n(1);
      repeat (2) @(posedge HCLK);

      check("apb_queue_drained", 96'(apb_q.size()), 96'd0);
      check("pix_queue_drained", 96'(pix_q.size()), 96'd0);
      check("start_count_final", 96'(start_seen), 96'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/apb_conv_regs.md
APB_CONV_REGS -- requirements
Module: apb_conv_regs

Interface
REQ-001 Parameter FIFO_DEPTH, default 6, row-word FIFO entries (two 28-pixel rows of 3 words each); power of two not required.
REQ-002 HCLK  in  1  single clock; all logic on rising edge.
REQ-003 HRESETn  in  1  asynchronous, active-low reset.
REQ-004 PADDR  in  12  APB byte address offset; bits [1:0] ignored.
REQ-005 PWDATA  in  32  APB write data.
REQ-006 PWRITE, PSEL, PENABLE  in  1 each  APB control.
REQ-007 PRDATA  out  32  read data, valid while PREADY=1 in the access phase.
REQ-008 PREADY  out  1  access-phase completion.
REQ-009 PSLVERR  out  1  error response.
REQ-010 filt_o  out  75  25 filter taps, tap r*5+c at bits [3*(r*5+c)+2 -: 3].
REQ-011 pix_data_o  out  30  FIFO head word; pix_idx_o  out  2  word index 0..2; pix_valid_o  out  1; pix_ready_i  in  1.
REQ-012 start_o  out  1  one-cycle start pulse to the convolution core.
REQ-013 row_done_i, chan_done_i  in  1 each  one-cycle event pulses from the core.

Function
REQ-014 Transfer completes on PSEL & PENABLE & PREADY; writes take effect only in that cycle.
REQ-015 Offset map: 0x500 CTRL (W), 0x504 STATUS (R), 0x508 ROW_DATA (W), 0x900/0x904/0x908 FILT0/1/2 (R/W).
REQ-016 FILT0 [29:0] = rows 0-1, FILT1 [29:0] = rows 2-3, FILT2 [14:0] = row 4; the leftmost pixel occupies the most significant 3-bit field; unused bits read 0.
REQ-017 ROW_DATA write pushes {PWDATA[29:0], word index} into the FIFO; the word index cycles 0,1,2,0 per push; for index 2, only [23:0] (8 pixels) is meaningful and stored unchanged.
REQ-018 ROW_DATA write with FIFO full: PREADY=0 in the access phase until an entry pops; the push then completes with PREADY=1.
REQ-019 All other accesses: PREADY=1 in the first access cycle (zero wait states).
REQ-020 FIFO pops when pix_valid_o & pix_ready_i; a push and pop in the same cycle on a full FIFO is not allowed, because the push waits one cycle per REQ-018.
REQ-021 CTRL write with PWDATA[0]=1 while not busy: start_o=1 the next cycle and busy is set; while busy it is ignored.
REQ-022 busy clears on row_done_i.
REQ-023 STATUS bits: [0] busy, [1] row_done sticky, [2] chan_done sticky, [3] FIFO full, [6:4] FIFO count (saturating display), others 0.
REQ-024 Sticky bits clear on a completed STATUS read; an event pulse in the same cycle wins and leaves the bit set.
REQ-025 Reads of write-only or unmapped offsets return 0.

Reset
REQ-026 HRESETn low asynchronously clears the FIFO, the word index, filters, busy and sticky bits; outputs PRDATA=0, PREADY=1, PSLVERR=0, start_o=0, pix_valid_o=0, filt_o=0.
REQ-027 Reset during a stalled access or an in-flight row abandons it with no partial state retained.

Configuration
REQ-028 With APB_CONV_REGS_SLVERR_EN defined: PSLVERR=1 on completion for unmapped offsets, reads of CTRL/ROW_DATA, and writes to STATUS; the write is discarded.
REQ-029 Without it, PSLVERR is tied 0 and those accesses are silently ignored or read 0.

Structure
REQ-030 Package apb_conv_pkg holds the register offsets, pixel width 3, filter size 5, row length 28, and STATUS bit positions.
REQ-031 Sub-module conv_word_fifo (synchronous FIFO with count, full, and empty outputs) is instantiated once.

Verification
REQ-032 Write FILT0=0x3FFFFFFF, FILT1=0, FILT2=0x00007FFF → filt_o[29:0] all ones, taps 10-19 zero, taps 20-24 all ones; readback matches.
REQ-033 Push 6 ROW_DATA words with no pops, then a 7th → 7th access holds PREADY=0; one pop releases it next cycle; count=6.
REQ-034 Push 3 words (0x12345678, 0x0, 0x00ABCDEF) → pix_idx_o sequence 0,1,2 with data 0x12345678&0x3FFFFFFF, 0, 0x00ABCDEF.
REQ-035 CTRL=1 → start_o pulses once; second CTRL=1 before row_done_i → no pulse; row_done_i → STATUS=0x2|count, then reads clear bit 1.
REQ-036 chan_done_i coincident with STATUS read completion → bit 2 remains set on the next read; HRESETn pulse mid-stall → all outputs at reset values.
REQ-037 Read 0x600 → PRDATA=0, PSLVERR=1 only when APB_CONV_REGS_SLVERR_EN is defined.
